exe_stage_muldiv: RTL and testbench
===================================

Name: exe_stage_muldiv

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Receives decoded operands and the 9-bit command bundle from the decode stage into an internal ID/EXE register.
- Applies MEM/WB forwarding, executes single-cycle ALU ops, runs an iterative 32-cycle multiply/divide sequencer, and resolves branches.
- Drives the registered EXE/MEM outputs, plus hazard/flush feedback to decode.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations per multiply/divide; fixed equal to XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- Commands  in  9  {EXE_CMD[5:0], MEM_CMD[1:0], WB_EN} from decode; all-zero = bubble.
- PC_ID  in  32  PC+4 of the decoding instruction.
- Val1_ID  in  32  rs value.
- Val2_ID  in  32  rt value or sign-extended immediate.
- Reg2_ID  in  32  rt value (store data).
- Src1_ID  in  5  rs index.
- Src2_ID  in  5  rt index.
- Dest_ID  in  5  destination index.
- WB_EN_MEM  in  1  MEM-stage write-back enable.
- Dest_MEM  in  5  MEM-stage destination.
- Result_MEM  in  32  MEM-stage ALU result.
- WB_EN  in  1  WB-stage write-back enable.
- Dst_WB  in  5  WB-stage destination.
- Result_WB  in  32  WB-stage result.
- WB_EN_EXE  out  1  ID/EXE WB_EN, fed to decode hazard detect.
- Dest_EXE  out  5  ID/EXE destination, fed to decode hazard detect.
- Branch_Predict  out  1  branch taken, combinational; decode uses it to flush.
- Branch_Addr  out  32  branch target, combinational.
- Busy  out  1  stall request to IF/ID, combinational.
- ALU_Result_M  out  32  registered result to MEM.
- Store_Val_M  out  32  registered forwarded rt value.
- Dest_M  out  5  registered destination.
- MEM_CMD_M  out  2  registered memory command.
- WB_EN_M  out  1  registered write-back enable.

Behaviour:
- EXE_CMD encoding:
  - bit5 = 1: operand B is Val2 (immediate); bit5 = 0: operand B is forwarded rt.
  - [4:0]: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 SLL, 8 SRL, 9 SRA, 10 SLT (signed), 11 MUL, 12 DIV (unsigned), 13 BEZ, 14 BNE, 15 JMP; others act as NOP.
- Reset:
  - ID/EXE register, all *_M outputs and FSM clear to 0 / IDLE.
  - Any in-flight multiply/divide is aborted, no result is emitted, and Busy drops in the cycle after reset.
- ID/EXE load rule:
  - Holds while Busy=1.
  - Loads a bubble (all fields 0) on an edge where Branch_Predict=1.
  - Otherwise loads the ID inputs.
- Forwarding:
  - Applies to A = fwd(Src1, Val1) and R = fwd(Src2, Reg2).
  - Priority: MEM (WB_EN_MEM && Dest_MEM == src) over WB (WB_EN && Dst_WB == src) over the ID value.
  - Source index 0 is never forwarded.
  - B = bit5 ? Val2 : R; Store_Val = R.
- Shifts use B[4:0]; SRA is arithmetic. ADD/SUB wrap modulo 2^32 with no overflow trap.
- Branches:
  - BEZ is taken if A == 0; BNE is taken if A != R; JMP is always taken.
  - Branch_Addr = PC + {Val2[29:0], 2'b00}.
  - Branches and NOP emit WB_EN_M = 0 and MEM_CMD_M = 0.
- Single-cycle op timing: the instruction sits in ID/EXE in cycle k; its results appear on *_M after edge k.
- Multiply/divide FSM, states IDLE, RUN, DONE:
  - IDLE with a MUL/DIV command in ID/EXE:
    - Busy = 1 and *_M receive a bubble.
    - At the edge, latch forwarded A/B, clear the accumulator, count = 0, go to RUN.
  - RUN:
    - Busy = 1 and *_M receive a bubble.
    - One iteration per edge: shift-add for MUL, restoring shift-subtract for DIV.
    - After 32 iterations (count == 31) go to DONE.
  - DONE:
    - Busy = 0.
    - At the edge, the result goes to ALU_Result_M with WB_EN_M / Dest_M from ID/EXE, ID/EXE loads the next instruction, and the FSM returns to IDLE.
  - Busy stays high for exactly 33 cycles; the result appears on *_M 34 edges after the instruction enters ID/EXE.
  - MUL result = low 32 bits of the product. DIV result = quotient.
  - Divide by zero gives 0xFFFFFFFF after the full 33 cycles.
- Operands are latched at IDLE→RUN, so WB/MEM retiring during RUN does not disturb them.
- Branch_Predict and Busy cannot be high together: a branch never occupies the multiply/divide FSM.

Test Plan:
- rst held 2 cycles mid-MUL (count = 10) → all *_M = 0, Busy = 0 the next cycle, FSM IDLE, no late result emitted.
- ADD r3, r1, r2 with r1 = 5, r2 = 7, then SUB r4, r3, r1 back-to-back → MEM-forwarded A = 12, ALU_Result_M = 7 with WB_EN_M = 1 and Dest_M = 4.
- MUL with A = 0x0001_0000, B = 0x0003_0000 → Busy high 33 cycles, ALU_Result_M = 0x0000_0000; 7 × 9 → 63 on the 34th edge.
- DIV 100 / 7 → 14; DIV 5 / 0 → 0xFFFFFFFF; both take the same cycle counts.
- BNE with A = 1, R = 2, PC = 0x40, Val2 = 3 → Branch_Predict = 1, Branch_Addr = 0x4C, next ID/EXE content is a bubble, WB_EN_M = 0.
- Src1 matches both Dest_MEM and Dst_WB (MEM = 0xAA, WB = 0xBB) → MEM value 0xAA used; Src1 = 0 with Dest_MEM = 0 → uses Val1_ID.

Source files
------------

// File: rtl/exe_stage_muldiv.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EXE register, MEM/WB forwarding,
// single-cycle ALU, iterative 32-step multiply/divide and branch resolution.
module exe_stage_muldiv #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [8:0]      Commands,
    input  logic [XLEN-1:0] PC_ID,
    input  logic [XLEN-1:0] Val1_ID,
    input  logic [XLEN-1:0] Val2_ID,
    input  logic [XLEN-1:0] Reg2_ID,
    input  logic [4:0]      Src1_ID,
    input  logic [4:0]      Src2_ID,
    input  logic [4:0]      Dest_ID,
    input  logic            WB_EN_MEM,
    input  logic [4:0]      Dest_MEM,
    input  logic [XLEN-1:0] Result_MEM,
    input  logic            WB_EN,
    input  logic [4:0]      Dst_WB,
    input  logic [XLEN-1:0] Result_WB,
    output logic            WB_EN_EXE,
    output logic [4:0]      Dest_EXE,
    output logic            Branch_Predict,
    output logic [XLEN-1:0] Branch_Addr,
    output logic            Busy,
    output logic [XLEN-1:0] ALU_Result_M,
    output logic [XLEN-1:0] Store_Val_M,
    output logic [4:0]      Dest_M,
    output logic [1:0]      MEM_CMD_M,
    output logic            WB_EN_M
);

    localparam int SH_W = $clog2(XLEN);
    localparam int CW   = $clog2(MD_CYCLES);

    localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3,  OP_OR  = 5'd4,
                           OP_XOR = 5'd5,  OP_NOR = 5'd6,  OP_SLL = 5'd7,  OP_SRL = 5'd8,
                           OP_SRA = 5'd9,  OP_SLT = 5'd10, OP_MUL = 5'd11, OP_DIV = 5'd12,
                           OP_BEZ = 5'd13, OP_BNE = 5'd14, OP_JMP = 5'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_e;

    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      src,
        input logic [XLEN-1:0] id_val,
        input logic            wb_mem,
        input logic [4:0]      dst_mem,
        input logic [XLEN-1:0] res_mem,
        input logic            wb_wb,
        input logic [4:0]      dst_wb,
        input logic [XLEN-1:0] res_wb
    );
        if (src != 5'd0 && wb_mem && dst_mem == src)     return res_mem;
        else if (src != 5'd0 && wb_wb && dst_wb == src)  return res_wb;
        else                                             return id_val;
    endfunction

    function automatic logic [XLEN-1:0] alu(
        input logic [4:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return a << b[SH_W-1:0];
            OP_SRL:  return a >> b[SH_W-1:0];
            OP_SRA:  return sa >>> b[SH_W-1:0];
            OP_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
            default: return '0;
        endcase
    endfunction

    logic [8:0]      cmd_q;
    logic [XLEN-1:0] pc_q, val1_q, val2_q, reg2_q;
    logic [4:0]      src1_q, src2_q, dest_q;

    logic            use_imm, wb_en;
    logic [4:0]      op;
    logic [1:0]      mem_cmd;
    logic [XLEN-1:0] a_fwd, r_fwd, b_op;
    logic            is_md, writes;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [XLEN:0]   rem_sh;

    logic [XLEN-1:0] res_q, store_q;
    logic [4:0]      dest_m_q;
    logic [1:0]      mem_m_q;
    logic            wb_m_q;

    assign {use_imm, op, mem_cmd, wb_en} = cmd_q;

    assign a_fwd = fwd(src1_q, val1_q, WB_EN_MEM, Dest_MEM, Result_MEM, WB_EN, Dst_WB, Result_WB);
    assign r_fwd = fwd(src2_q, reg2_q, WB_EN_MEM, Dest_MEM, Result_MEM, WB_EN, Dst_WB, Result_WB);
    assign b_op  = use_imm ? val2_q : r_fwd;

    assign is_md  = (op == OP_MUL) || (op == OP_DIV);
    assign writes = (op >= OP_ADD) && (op <= OP_SLT);

    assign Branch_Predict = (op == OP_JMP) ||
                            (op == OP_BEZ && a_fwd == '0) ||
                            (op == OP_BNE && a_fwd != r_fwd);
    assign Branch_Addr    = pc_q + {val2_q[XLEN-3:0], 2'b00};
    assign Busy           = (state_q == IDLE && is_md) || (state_q == RUN);

    assign WB_EN_EXE    = wb_en;
    assign Dest_EXE     = dest_q;
    assign ALU_Result_M = res_q;
    assign Store_Val_M  = store_q;
    assign Dest_M       = dest_m_q;
    assign MEM_CMD_M    = mem_m_q;
    assign WB_EN_M      = wb_m_q;

    // ID/EXE boundary: hold while stalled, squash behind a taken branch
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q  <= '0;
            pc_q   <= '0;
            val1_q <= '0;
            val2_q <= '0;
            reg2_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dest_q <= '0;
        end else if (!Busy) begin
            if (Branch_Predict) begin
                cmd_q  <= '0;
                pc_q   <= '0;
                val1_q <= '0;
                val2_q <= '0;
                reg2_q <= '0;
                src1_q <= '0;
                src2_q <= '0;
                dest_q <= '0;
            end else begin
                cmd_q  <= Commands;
                pc_q   <= PC_ID;
                val1_q <= Val1_ID;
                val2_q <= Val2_ID;
                reg2_q <= Reg2_ID;
                src1_q <= Src1_ID;
                src2_q <= Src2_ID;
                dest_q <= Dest_ID;
            end
        end
    end

    // Multiply/divide sequencer: acc is the product or the partial remainder,
    // opa is the multiplier or the dividend that becomes the quotient.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_sh  = '0;
        case (state_q)
            IDLE: begin
                if (is_md) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    opa_d   = a_fwd;
                    opb_d   = b_op;
                end
            end
            RUN: begin
                if (op == OP_DIV) begin
                    rem_sh = {acc_q, opa_q[XLEN-1]};
                    opa_d  = {opa_q[XLEN-2:0], 1'b0};
                    if (rem_sh >= {1'b0, opb_q}) begin
                        acc_d    = rem_sh[XLEN-1:0] - opb_q;
                        opa_d[0] = 1'b1;
                    end else begin
                        acc_d = rem_sh[XLEN-1:0];
                    end
                end else begin
                    if (opa_q[0]) acc_d = acc_q + opb_q;
                    opa_d = opa_q >> 1;
                    opb_d = opb_q << 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MD_CYCLES - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

    // EXE/MEM boundary
    always_ff @(posedge clk) begin
        if (rst || Busy) begin
            res_q    <= '0;
            store_q  <= '0;
            dest_m_q <= '0;
            mem_m_q  <= '0;
            wb_m_q   <= 1'b0;
        end else if (state_q == DONE) begin
            res_q    <= (op == OP_DIV) ? opa_q : acc_q;
            store_q  <= r_fwd;
            dest_m_q <= dest_q;
            mem_m_q  <= mem_cmd;
            wb_m_q   <= wb_en;
        end else begin
            res_q    <= alu(op, a_fwd, b_op);
            store_q  <= r_fwd;
            dest_m_q <= dest_q;
            mem_m_q  <= writes ? mem_cmd : 2'b00;
            wb_m_q   <= writes ? wb_en : 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Directed bench for exe_stage_muldiv: forwarding, ALU, mul/div timing, branches, reset.
module tb_exe_stage_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  Commands;
    logic [31:0] PC_ID, Val1_ID, Val2_ID, Reg2_ID;
    logic [4:0]  Src1_ID, Src2_ID, Dest_ID;
    logic        WB_EN_MEM;
    logic [4:0]  Dest_MEM;
    logic [31:0] Result_MEM;
    logic        WB_EN;
    logic [4:0]  Dst_WB;
    logic [31:0] Result_WB;
    logic        WB_EN_EXE;
    logic [4:0]  Dest_EXE;
    logic        Branch_Predict;
    logic [31:0] Branch_Addr;
    logic        Busy;
    logic [31:0] ALU_Result_M, Store_Val_M;
    logic [4:0]  Dest_M;
    logic [1:0]  MEM_CMD_M;
    logic        WB_EN_M;

    int n_cmp = 0;
    int n_err = 0;

    exe_stage_muldiv dut (
        .clk(clk), .rst(rst), .Commands(Commands), .PC_ID(PC_ID),
        .Val1_ID(Val1_ID), .Val2_ID(Val2_ID), .Reg2_ID(Reg2_ID),
        .Src1_ID(Src1_ID), .Src2_ID(Src2_ID), .Dest_ID(Dest_ID),
        .WB_EN_MEM(WB_EN_MEM), .Dest_MEM(Dest_MEM), .Result_MEM(Result_MEM),
        .WB_EN(WB_EN), .Dst_WB(Dst_WB), .Result_WB(Result_WB),
        .WB_EN_EXE(WB_EN_EXE), .Dest_EXE(Dest_EXE),
        .Branch_Predict(Branch_Predict), .Branch_Addr(Branch_Addr), .Busy(Busy),
        .ALU_Result_M(ALU_Result_M), .Store_Val_M(Store_Val_M), .Dest_M(Dest_M),
        .MEM_CMD_M(MEM_CMD_M), .WB_EN_M(WB_EN_M)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] cmd9(input logic [5:0] exe, input logic [1:0] mem, input logic wb);
        return {exe, mem, wb};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] c, input logic [31:0] pc, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] r2,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        Commands = c; PC_ID = pc; Val1_ID = v1; Val2_ID = v2; Reg2_ID = r2;
        Src1_ID = s1; Src2_ID = s2; Dest_ID = d;
    endtask

    task automatic bubble();
        drive(9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic fwd_set(input logic wm, input logic [4:0] dm, input logic [31:0] rm,
                           input logic ww, input logic [4:0] dw, input logic [31:0] rw);
        WB_EN_MEM = wm; Dest_MEM = dm; Result_MEM = rm;
        WB_EN = ww; Dst_WB = dw; Result_WB = rw;
    endtask

    // Issue one single-cycle instruction; afterwards its result sits on *_M.
    task automatic run1(input logic [8:0] c, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [4:0] s1, input logic [4:0] d);
        drive(c, 32'd0, v1, v2, 32'd0, s1, 5'd0, d);
        tick();
        bubble();
        tick();
    endtask

    // Issue a mul/div, queue an ADD behind it, count Busy cycles, check result and the held ADD.
    task automatic md_run(input string tag, input logic [5:0] exe, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        int n;
        logic wb_seen;
        drive(cmd9(exe, 2'b00, 1'b1), 32'd0, a, b, 32'd0, 5'd0, 5'd0, d);
        tick();
        drive(cmd9(6'b100001, 2'b00, 1'b1), 32'd0, 32'h100, 32'd1, 32'd0, 5'd0, 5'd0, 5'd9);
        n = 0;
        wb_seen = 1'b0;
        while (Busy && n < 100) begin
            n++;
            tick();
            if (Busy && WB_EN_M) wb_seen = 1'b1;
        end
        check_val({tag, "_busy_cycles"}, n, 33);
        check_val({tag, "_bubble_wb"}, {31'd0, wb_seen}, 32'd0);
        tick();
        check_val({tag, "_result"}, ALU_Result_M, exp);
        check_val({tag, "_dest"}, {27'd0, Dest_M}, {27'd0, d});
        check_val({tag, "_wb"}, {31'd0, WB_EN_M}, 32'd1);
        bubble();
        tick();
        check_val({tag, "_held_add"}, ALU_Result_M, 32'h101);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        bubble();
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) tick();
        check_val("rst_result", ALU_Result_M, 32'd0);
        check_val("rst_wb", {31'd0, WB_EN_M}, 32'd0);
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_bp", {31'd0, Branch_Predict}, 32'd0);
        rst = 1'b0;
        tick();

        // ADD r3,r1,r2 then SUB r4,r3,r1 with r3 forwarded from MEM
        drive(cmd9(6'b000001, 2'b00, 1'b1), 32'd0, 32'd5, 32'd7, 32'd7, 5'd1, 5'd2, 5'd3);
        tick();
        drive(cmd9(6'b000010, 2'b00, 1'b1), 32'd0, 32'd0, 32'd5, 32'd5, 5'd3, 5'd1, 5'd4);
        tick();
        check_val("add_result", ALU_Result_M, 32'd12);
        check_val("add_dest", {27'd0, Dest_M}, 32'd3);
        fwd_set(1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'd0);
        bubble();
        tick();
        check_val("sub_result", ALU_Result_M, 32'd7);
        check_val("sub_wb", {31'd0, WB_EN_M}, 32'd1);
        check_val("sub_dest", {27'd0, Dest_M}, 32'd4);

        // Forwarding priority
        fwd_set(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
        run1(cmd9(6'b100001, 2'b00, 1'b1), 32'h11, 32'd0, 5'd9, 5'd5);
        check_val("fwd_mem_over_wb", ALU_Result_M, 32'hAA);
        fwd_set(1'b0, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
        run1(cmd9(6'b100001, 2'b00, 1'b1), 32'h11, 32'd0, 5'd9, 5'd5);
        check_val("fwd_wb_only", ALU_Result_M, 32'hBB);
        fwd_set(1'b1, 5'd0, 32'hAA, 1'b0, 5'd0, 32'd0);
        run1(cmd9(6'b100001, 2'b00, 1'b1), 32'h33, 32'd0, 5'd0, 5'd5);
        check_val("fwd_r0_never", ALU_Result_M, 32'h33);
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Other ALU patterns
        run1(cmd9(6'b101001, 2'b00, 1'b1), 32'h8000_0000, 32'd4, 5'd0, 5'd6);
        check_val("sra", ALU_Result_M, 32'hF800_0000);
        run1(cmd9(6'b101010, 2'b00, 1'b1), 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd6);
        check_val("slt_signed", ALU_Result_M, 32'd1);
        run1(cmd9(6'b100110, 2'b00, 1'b1), 32'hF0F0_0000, 32'h0000_F0F0, 5'd0, 5'd6);
        check_val("nor", ALU_Result_M, 32'h0F0F_0F0F);

        // Multiply / divide
        md_run("mul_hi", 6'b101011, 32'h0001_0000, 32'h0003_0000, 5'd8, 32'h0000_0000);
        md_run("mul_7x9", 6'b101011, 32'd7, 32'd9, 5'd8, 32'd63);
        md_run("div_100_7", 6'b101100, 32'd100, 32'd7, 5'd11, 32'd14);
        md_run("div_by_0", 6'b101100, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);

        // BNE taken; the instruction behind it must be squashed
        drive(cmd9(6'b001110, 2'b00, 1'b0), 32'h40, 32'd1, 32'd3, 32'd2, 5'd1, 5'd2, 5'd0);
        tick();
        check_val("bne_taken", {31'd0, Branch_Predict}, 32'd1);
        check_val("bne_addr", Branch_Addr, 32'h4C);
        check_val("bne_not_busy", {31'd0, Busy}, 32'd0);
        drive(cmd9(6'b100001, 2'b00, 1'b1), 32'd0, 32'd5, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7);
        tick();
        check_val("bne_wb_m", {31'd0, WB_EN_M}, 32'd0);
        check_val("squash_wb_exe", {31'd0, WB_EN_EXE}, 32'd0);
        check_val("squash_dest_exe", {27'd0, Dest_EXE}, 32'd0);
        bubble();
        tick();
        check_val("squash_wb_m", {31'd0, WB_EN_M}, 32'd0);

        // BEZ not taken, JMP with negative offset
        drive(cmd9(6'b001101, 2'b00, 1'b0), 32'h80, 32'd1, 32'd2, 32'd0, 5'd1, 5'd0, 5'd0);
        tick();
        check_val("bez_not_taken", {31'd0, Branch_Predict}, 32'd0);
        drive(cmd9(6'b001111, 2'b00, 1'b0), 32'h100, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check_val("jmp_taken", {31'd0, Branch_Predict}, 32'd1);
        check_val("jmp_addr", Branch_Addr, 32'h0000_00FC);
        bubble();
        tick();

        // Reset in the middle of a multiply
        drive(cmd9(6'b101011, 2'b00, 1'b1), 32'd0, 32'd7, 32'd9, 32'd0, 5'd0, 5'd0, 5'd10);
        tick();
        bubble();
        repeat (11) tick();
        check_val("mid_mul_busy", {31'd0, Busy}, 32'd1);
        rst = 1'b1;
        tick();
        check_val("rst_mul_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_mul_result", ALU_Result_M, 32'd0);
        check_val("rst_mul_dest_exe", {27'd0, Dest_EXE}, 32'd0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Busy || WB_EN_M || ALU_Result_M != 32'd0) bad++;
        end
        check_val("no_late_result", bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
